fft: RTL and testbench

FFT -- requirements
Module: fft

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_butterfly.sv | 50 +++++
 rtl/fft.sv | 75 +++++++
 tb/tb_fft.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, Q1.14 twiddle table and helpers for the 16-point FFT
package fft_pkg;

  localparam int N    = 16;
  localparam int W    = 16;
  localparam int FRAC = 14;

  localparam logic signed [W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W-1:0] SAT_MIN = 16'sh8000;

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), k = 0..7, rounded to nearest
  localparam logic signed [W-1:0] TW_RE [0:7] = '{
    16'sh4000, 16'sh3B21, 16'sh2D41, 16'sh187E,
    16'sh0000, 16'shE782, 16'shD2BF, 16'shC4DF
  };
  localparam logic signed [W-1:0] TW_IM [0:7] = '{
    16'sh0000, 16'shE782, 16'shD2BF, 16'shC4DF,
    16'shC000, 16'shC4DF, 16'shD2BF, 16'shE782
  };

  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > (W+2)'(SAT_MAX)) return SAT_MAX;
    if (v < (W+2)'(SAT_MIN)) return SAT_MIN;
    return v[W-1:0];
  endfunction

  function automatic int bit_rev(input int i, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) r = r | (((i >> b) & 1) << (bits - 1 - b));
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - combinational radix-2 DIT butterfly with constant twiddle and saturation
module fft_butterfly #(
  parameter int W    = fft_pkg::W,
  parameter int FRAC = fft_pkg::FRAC,
  parameter int TW   = 0
) (
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y0_r,
  output logic signed [W-1:0] y0_i,
  output logic signed [W-1:0] y1_r,
  output logic signed [W-1:0] y1_i
);
  import fft_pkg::*;

  localparam logic signed [W-1:0] WR  = TW_RE[TW];
  localparam logic signed [W-1:0] WI  = TW_IM[TW];
  localparam logic signed [31:0]  RND = 32'sd1 <<< (FRAC - 1);

  logic signed [31:0]  pr;
  logic signed [31:0]  pi;
  logic signed [W+1:0] tr;
  logic signed [W+1:0] ti;

  // Twiddles 1 and -j are pure routing; the branch is constant per instance.
  always_comb begin
    pr = '0;
    pi = '0;
    if (TW == 0) begin
      tr = (W+2)'(b_r);
      ti = (W+2)'(b_i);
    end else if (TW == N / 4) begin
      tr = (W+2)'(b_i);
      ti = -(W+2)'(b_r);
    end else begin
      pr = 32'(b_r) * 32'(WR) - 32'(b_i) * 32'(WI) + RND;
      pi = 32'(b_r) * 32'(WI) + 32'(b_i) * 32'(WR) + RND;
      tr = (W+2)'(pr >>> FRAC);
      ti = (W+2)'(pi >>> FRAC);
    end
  end

  assign y0_r = sat((W+2)'(a_r) + tr);
  assign y0_i = sat((W+2)'(a_i) + ti);
  assign y1_r = sat((W+2)'(a_r) - tr);
  assign y1_i = sat((W+2)'(a_i) - ti);

endmodule

// File: rtl/fft.sv
// rtl/fft.sv - fully pipelined 16-point radix-2 DIT FFT, one frame per clock, latency 6 edges
module fft #(
  parameter int N    = fft_pkg::N,
  parameter int W    = fft_pkg::W,
  parameter int FRAC = fft_pkg::FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] Xin_r  [0:N-1],
  input  logic signed [W-1:0] Xin_i  [0:N-1],
  output logic signed [W-1:0] Xout_r [0:N-1],
  output logic signed [W-1:0] Xout_i [0:N-1]
);
  import fft_pkg::*;

  localparam int STAGES = $clog2(N);

  // pipe[0] is the bit-reversed input register, pipe[s+1] holds stage s results
  logic signed [W-1:0] pipe_r [0:STAGES][0:N-1];
  logic signed [W-1:0] pipe_i [0:STAGES][0:N-1];
  logic signed [W-1:0] bf_r   [0:STAGES-1][0:N-1];
  logic signed [W-1:0] bf_i   [0:STAGES-1][0:N-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar b = 0; b < N / 2; b++) begin : g_bf
      localparam int HALF = 1 << s;
      localparam int POS  = b % HALF;
      localparam int TOP  = (b / HALF) * 2 * HALF + POS;
      localparam int BOT  = TOP + HALF;
      localparam int TWI  = POS << (STAGES - 1 - s);

      fft_butterfly #(.W(W), .FRAC(FRAC), .TW(TWI)) u_bf (
        .a_r  (pipe_r[s][TOP]),
        .a_i  (pipe_i[s][TOP]),
        .b_r  (pipe_r[s][BOT]),
        .b_i  (pipe_i[s][BOT]),
        .y0_r (bf_r[s][TOP]),
        .y0_i (bf_i[s][TOP]),
        .y1_r (bf_r[s][BOT]),
        .y1_i (bf_i[s][BOT])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        for (int i = 0; i < N; i++) begin
          pipe_r[s][i] <= '0;
          pipe_i[s][i] <= '0;
        end
      end
      for (int i = 0; i < N; i++) begin
        Xout_r[i] <= '0;
        Xout_i[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        pipe_r[0][i] <= Xin_r[bit_rev(i, STAGES)];
        pipe_i[0][i] <= Xin_i[bit_rev(i, STAGES)];
      end
      for (int s = 0; s < STAGES; s++) begin
        for (int i = 0; i < N; i++) begin
          pipe_r[s+1][i] <= bf_r[s][i];
          pipe_i[s+1][i] <= bf_i[s][i];
        end
      end
      for (int i = 0; i < N; i++) begin
        Xout_r[i] <= pipe_r[STAGES][i];
        Xout_i[i] <= pipe_i[STAGES][i];
      end
    end
  end

endmodule

// File: tb/tb_fft.sv
// tb/tb_fft.sv - self-checking bench for fft against a saturating fixed-point DFT reference
module tb_fft;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic signed [15:0] xin_r  [0:15];
  logic signed [15:0] xin_i  [0:15];
  logic signed [15:0] xout_r [0:15];
  logic signed [15:0] xout_i [0:15];

  typedef struct {
    int r [16];
    int i [16];
  } frame_t;

  frame_t q[$];
  frame_t cur;
  frame_t f;
  int twr [8];
  int twi [8];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fft #(.N(16), .W(16), .FRAC(14)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Xin_r  (xin_r),
    .Xin_i  (xin_i),
    .Xout_r (xout_r),
    .Xout_i (xout_i)
  );

  always #5 clk = ~clk;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int sat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic frame_t zero_frame();
    frame_t z;
    for (int n = 0; n < 16; n++) begin
      z.r[n] = 0;
      z.i[n] = 0;
    end
    return z;
  endfunction

  function automatic frame_t rand_frame(int amp);
    frame_t z;
    for (int n = 0; n < 16; n++) begin
      z.r[n] = int'($urandom_range(0, 2 * amp - 1)) - amp;
      z.i[n] = int'($urandom_range(0, 2 * amp - 1)) - amp;
    end
    return z;
  endfunction

  // Iterative DIT DFT: bit-reversed load, then log2(16) passes of twiddled sum/difference,
  // each pass rounded half-up and clamped to 16-bit range.
  function automatic frame_t ref_fft(frame_t x);
    frame_t a;
    longint tr, ti;
    int rv, k, half, ur, ui, br, bi;
    for (int n = 0; n < 16; n++) begin
      rv = 0;
      for (int b = 0; b < 4; b++) rv = rv | (((n >> b) & 1) << (3 - b));
      a.r[n] = x.r[rv];
      a.i[n] = x.i[rv];
    end
    for (int len = 2; len <= 16; len = len * 2) begin
      half = len / 2;
      for (int base = 0; base < 16; base += len) begin
        for (int j = 0; j < half; j++) begin
          k  = j * (16 / len);
          ur = a.r[base + j];
          ui = a.i[base + j];
          br = a.r[base + j + half];
          bi = a.i[base + j + half];
          tr = (longint'(br) * twr[k] - longint'(bi) * twi[k] + 8192) >>> 14;
          ti = (longint'(br) * twi[k] + longint'(bi) * twr[k] + 8192) >>> 14;
          a.r[base + j]        = sat(ur + tr);
          a.i[base + j]        = sat(ui + ti);
          a.r[base + j + half] = sat(ur - tr);
          a.i[base + j + half] = sat(ui - ti);
        end
      end
    end
    return a;
  endfunction

  task automatic drive(frame_t d);
    cur = d;
    for (int n = 0; n < 16; n++) begin
      xin_r[n] = 16'(d.r[n]);
      xin_i[n] = 16'(d.i[n]);
    end
  endtask

  task automatic check_bin(string tag, int k, logic signed [15:0] obs, logic signed [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] cycle %0d observed %h expected %h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic check_frame(frame_t e, string tag);
    for (int k = 0; k < 16; k++) begin
      check_bin({tag, "_r"}, k, xout_r[k], 16'(e.r[k]));
      check_bin({tag, "_i"}, k, xout_i[k], 16'(e.i[k]));
    end
  endtask

  // One clock: compare output to the frame driven six edges earlier, then drive the next frame.
  task automatic cycle(frame_t d);
    @(negedge clk);
    cyc++;
    check_frame(q.pop_front(), "pipe");
    drive(d);
    q.push_back(ref_fft(d));
  endtask

  // After reset release the frame currently on the inputs is the first one sampled.
  task automatic restart();
    q.delete();
    repeat (5) q.push_back(zero_frame());
    q.push_back(ref_fft(cur));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      twr[k] = rnd($cos(2.0 * 3.14159265358979 * k / 16.0) * 16384.0);
      twi[k] = -rnd($sin(2.0 * 3.14159265358979 * k / 16.0) * 16384.0);
    end

    drive(zero_frame());
    #1 rst_n = 1'b0;
    #1 check_frame(zero_frame(), "reset");
    repeat (2) @(posedge clk);
    #1 check_frame(zero_frame(), "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    restart();
    repeat (8) cycle(zero_frame());

    f = zero_frame();
    f.r[0] = 16'sh2000;
    repeat (4) cycle(f);
    repeat (3) cycle(zero_frame());
    for (int k = 0; k < 16; k++) begin
      check_bin("impulse_r", k, xout_r[k], 16'sh2000);
      check_bin("impulse_i", k, xout_i[k], 16'sh0000);
    end

    for (int n = 0; n < 16; n++) f.r[n] = 16'sh1000;
    cycle(f);
    repeat (6) cycle(zero_frame());
    check_bin("dc_r", 0, xout_r[0], 16'sh7FFF);
    for (int k = 1; k < 16; k++) begin
      check_bin("dc_r", k, xout_r[k], 16'sh0000);
      check_bin("dc_i", k, xout_i[k], 16'sh0000);
    end

    for (int n = 0; n < 16; n++) begin
      f.r[n] = rnd($cos(2.0 * 3.14159265358979 * n / 16.0) * 16384.0);
      f.i[n] = rnd($sin(2.0 * 3.14159265358979 * n / 16.0) * 16384.0);
    end
    cycle(f);
    repeat (6) cycle(zero_frame());
    check_bin("tone_r", 1, xout_r[1], 16'sh7FFF);

    repeat (30) cycle(rand_frame(2048));
    repeat (30) cycle(rand_frame(32768));

    repeat (3) cycle(rand_frame(8192));
    #1 rst_n = 1'b0;
    #1 check_frame(zero_frame(), "async_reset");
    @(negedge clk);
    check_frame(zero_frame(), "mid_reset_hold");
    rst_n = 1'b1;
    drive(rand_frame(4096));
    restart();
    repeat (20) cycle(rand_frame(8192));
    repeat (6) cycle(zero_frame());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
